// File: rtl/pulse_width_counter.sv
// pulse_width_counter
// Measures how many clock cycles pulse_in stays high, then converts that
// cycle count into whole milliseconds with a restoring shift-subtract
// divider (one quotient bit per cycle). A one-cycle done_tick marks a fresh
// result. read_time copies the current millisecond result into a history
// register that the host can poll at its leisure.

module pulse_width_counter #(
  parameter int CLKS_PER_MS = 50_000,  // divisor, must be >= 1
  parameter int COUNT_W     = 20,      // width of the cycle counter
  parameter int TIME_W      = 32       // width of the millisecond results
) (
  input  logic               clk,
  input  logic               rst,           // asynchronous, active low
  input  logic               pulse_in,
  input  logic               read_time,
  output logic               ready,
  output logic               done_tick,
  output logic [COUNT_W-1:0] count,
  output logic [TIME_W-1:0]  time_ms,
  output logic [TIME_W-1:0]  last_time_ms
);

  // Remainder must hold any value below the divisor plus one shifted-in bit.
  localparam int DIVISOR_W = $clog2(CLKS_PER_MS + 1);
  localparam int REM_W     = ((COUNT_W > DIVISOR_W) ? COUNT_W : DIVISOR_W) + 1;
  localparam int BITCNT_W  = $clog2(COUNT_W + 1);

  localparam logic [REM_W-1:0]    DIVISOR   = REM_W'(CLKS_PER_MS);
  localparam logic [COUNT_W-1:0]  COUNT_MAX = {COUNT_W{1'b1}};
  localparam logic [BITCNT_W-1:0] LAST_BIT  = BITCNT_W'(COUNT_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_DIVIDE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t              state_r;
  logic                pulse_prev_r;
  logic [COUNT_W-1:0]  count_r;
  logic [TIME_W-1:0]   time_r;
  logic [TIME_W-1:0]   last_time_r;

  // Divider working registers: quo_r starts as the dividend and has the
  // quotient bits shifted in from the right as the dividend bits leave at
  // the left, so after COUNT_W steps it holds the full quotient.
  logic [REM_W-1:0]    rem_r;
  logic [COUNT_W-1:0]  quo_r;
  logic [BITCNT_W-1:0] bit_cnt_r;

  logic [REM_W-1:0]    rem_shift_s;
  logic [REM_W-1:0]    rem_diff_s;
  logic                rem_fits_s;
  logic [COUNT_W-1:0]  quo_next_s;
  logic                ready_s;
  logic                done_s;

  // One restoring-division step: shift in the next dividend bit and
  // subtract the divisor when it fits.
  always_comb begin
    rem_shift_s = {rem_r[REM_W-2:0], quo_r[COUNT_W-1]};
    rem_diff_s  = rem_shift_s - DIVISOR;
    rem_fits_s  = (rem_shift_s >= DIVISOR);
    quo_next_s  = {quo_r[COUNT_W-2:0], rem_fits_s};
  end

  // Status strobes decoded directly from the state register.
  always_comb begin
    ready_s = 1'b0;
    done_s  = 1'b0;
    if (state_r == ST_IDLE) begin
      ready_s = 1'b1;
    end else if (state_r == ST_DONE) begin
      done_s = 1'b1;
    end else begin
      ready_s = 1'b0;
      done_s  = 1'b0;
    end
  end

  // Previous-cycle copy of pulse_in for rising-edge detection in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pulse_prev_r <= 1'b0;
    end else begin
      pulse_prev_r <= pulse_in;
    end
  end

  // History register: copies the current result whenever read_time is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_time_r <= {TIME_W{1'b0}};
    end else if (read_time) begin
      last_time_r <= time_r;
    end else begin
      last_time_r <= last_time_r;
    end
  end

  // Measurement FSM: wait for a rising edge, count high cycles, divide, flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      count_r   <= {COUNT_W{1'b0}};
      time_r    <= {TIME_W{1'b0}};
      rem_r     <= {REM_W{1'b0}};
      quo_r     <= {COUNT_W{1'b0}};
      bit_cnt_r <= {BITCNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          // A pulse that is already high on entry has no visible rising
          // edge, so it is deliberately not measured.
          if (pulse_in && !pulse_prev_r) begin
            count_r <= COUNT_W'(1);
            state_r <= ST_COUNT;
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_COUNT: begin
          if (pulse_in) begin
            // Saturate rather than wrap so very long pulses read as maximum.
            if (count_r != COUNT_MAX) begin
              count_r <= count_r + COUNT_W'(1);
            end else begin
              count_r <= count_r;
            end
          end else begin
            quo_r     <= count_r;
            rem_r     <= {REM_W{1'b0}};
            bit_cnt_r <= LAST_BIT;
            state_r   <= ST_DIVIDE;
          end
        end

        ST_DIVIDE: begin
          rem_r <= rem_fits_s ? rem_diff_s : rem_shift_s;
          quo_r <= quo_next_s;
          if (bit_cnt_r == {BITCNT_W{1'b0}}) begin
            time_r  <= TIME_W'(quo_next_s);
            state_r <= ST_DONE;
          end else begin
            bit_cnt_r <= bit_cnt_r - BITCNT_W'(1);
          end
        end

        ST_DONE: begin
          state_r <= ST_IDLE;
        end

        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready        = ready_s;
  assign done_tick    = done_s;
  assign count        = count_r;
  assign time_ms      = time_r;
  assign last_time_ms = last_time_r;

endmodule

// File: tb/tb_pulse_width_counter.sv
// Self-checking bench for pulse_width_counter. Uses a small divisor and
// counter width so saturation and ms boundaries are reached quickly. The
// reference is transaction-level: a pulse of w sampled-high cycles yields
// count = min(w, 2^CW-1) and time_ms = count / CLKS, delivered with
// done_tick exactly CW+1 edges after the first low sample.

module tb_pulse_width_counter;

  localparam int CLKS = 50;
  localparam int CW   = 10;
  localparam int TW   = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          pulse_in;
  logic          read_time;
  logic          ready;
  logic          done_tick;
  logic [CW-1:0] count;
  logic [TW-1:0] time_ms;
  logic [TW-1:0] last_time_ms;

  int n_checks;
  int n_fail;

  int exp_count;
  int exp_time;
  int exp_last;

  pulse_width_counter #(
    .CLKS_PER_MS(CLKS),
    .COUNT_W    (CW),
    .TIME_W     (TW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pulse_in    (pulse_in),
    .read_time   (read_time),
    .ready       (ready),
    .done_tick   (done_tick),
    .count       (count),
    .time_ms     (time_ms),
    .last_time_ms(last_time_ms)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; returns at the falling edge, away from the active edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_ready"}, 64'(ready), 64'd1);
    check_eq({tag, "_done"}, 64'(done_tick), 64'd0);
    check_eq({tag, "_count"}, 64'(count), 64'(exp_count));
    check_eq({tag, "_time"}, 64'(time_ms), 64'(exp_time));
    check_eq({tag, "_last"}, 64'(last_time_ms), 64'(exp_last));
  endtask

  // One full measurement. Precondition: idle, pulse_in low for >= 1 cycle.
  //   w          : number of edges sampling pulse_in high
  //   final_high : pulse_in level left on when IDLE is re-entered
  //   hold       : cycles to keep that level high (not a new measurement)
  //   rd_k       : falling edge (1..CW+1 after the drop) where read_time pulses
  task automatic measure(input int w, input bit final_high, input int hold, input int rd_k);
    int old_time;
    int new_time;
    check_eq("start_ready", 64'(ready), 64'd1);
    pulse_in = 1'b1;
    for (int k = 1; k <= w; k++) begin
      tick();
      if (k == 1) check_eq("count_first", 64'(count), 64'd1);
      if (k == w) begin
        check_eq("count_run", 64'(count), 64'((w > CMAX) ? CMAX : w));
        check_eq("busy_ready", 64'(ready), 64'd0);
      end
    end
    pulse_in  = 1'b0;
    old_time  = exp_time;
    exp_count = (w > CMAX) ? CMAX : w;
    new_time  = exp_count / CLKS;
    for (int k = 1; k <= CW + 1; k++) begin
      tick();
      if (read_time) read_time = 1'b0;
      if (k <= CW) begin
        check_eq("div_done", 64'(done_tick), 64'd0);
        check_eq("div_ready", 64'(ready), 64'd0);
      end
      if (k == CW) check_eq("time_before", 64'(time_ms), 64'(old_time));
      if (k == CW + 1) begin
        check_eq("done_tick", 64'(done_tick), 64'd1);
        check_eq("done_ready", 64'(ready), 64'd0);
        check_eq("done_count", 64'(count), 64'(exp_count));
        check_eq("done_time", 64'(time_ms), 64'(new_time));
      end
      // Activity while dividing must be ignored; settle to final level in DONE.
      if (k < CW + 1) pulse_in = 1'($urandom_range(0, 1));
      else            pulse_in = final_high;
      if (k == rd_k) begin
        read_time = 1'b1;
        exp_last  = (rd_k <= CW) ? old_time : new_time;
      end
    end
    exp_time = new_time;
    tick();
    read_time = 1'b0;
    check_eq("post_done", 64'(done_tick), 64'd0);
    check_eq("post_ready", 64'(ready), 64'd1);
    if (final_high) begin
      for (int h = 0; h < hold; h++) tick();
      check_eq("held_ready", 64'(ready), 64'd1);
      check_eq("held_count", 64'(count), 64'(exp_count));
      pulse_in = 1'b0;
    end
    for (int i = 0; i < 1 + int'($urandom_range(0, 2)); i++) tick();
    check_idle_outputs("idle");
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_count = 0;
    exp_time  = 0;
    exp_last  = 0;
    rst       = 1'b0;
    pulse_in  = 1'b0;
    read_time = 1'b0;

    // Reset held while the input toggles.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pulse_in = ~pulse_in;
    end
    @(negedge clk);
    check_idle_outputs("reset");
    pulse_in = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    check_idle_outputs("release");

    // Directed cases: short, multi-ms, exact boundaries, saturation.
    measure(5,    1'b0, 0, CW + 1);
    check_eq("short_last", 64'(last_time_ms), 64'd0);
    measure(150,  1'b0, 0, CW + 1);
    check_eq("multi_last3", 64'(last_time_ms), 64'd3);
    measure(125,  1'b1, 4, CW + 1);
    check_eq("multi_last2", 64'(last_time_ms), 64'd2);
    measure(49,   1'b0, 0, CW);
    measure(50,   1'b0, 0, CW + 1);
    check_eq("bound_50", 64'(time_ms), 64'd1);
    measure(100,  1'b1, 2, 1);
    check_eq("bound_100", 64'(time_ms), 64'd2);
    measure(1100, 1'b0, 0, CW + 1);
    check_eq("sat_count", 64'(count), 64'(CMAX));
    check_eq("sat_time", 64'(time_ms), 64'd20);
    measure(1,    1'b0, 0, 3);

    // Reset in the middle of a count: no done_tick, everything cleared.
    pulse_in = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b0;
    #1;
    exp_count = 0;
    exp_time  = 0;
    exp_last  = 0;
    check_idle_outputs("midrst");
    tick();
    pulse_in = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < CW + 4; i++) begin
      tick();
      check_eq("midrst_nodone", 64'(done_tick), 64'd0);
    end
    check_idle_outputs("midrst_after");

    // Randomized measurements plus idle reads.
    for (int n = 0; n < 14; n++) begin
      measure(int'($urandom_range(1, 1200)), 1'($urandom_range(0, 1)),
              int'($urandom_range(1, 5)), int'($urandom_range(1, CW + 1)));
      if ($urandom_range(0, 1) == 1) begin
        read_time = 1'b1;
        tick();
        tick();
        read_time = 1'b0;
        exp_last  = exp_time;
        tick();
        check_idle_outputs("idle_read");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_width_counter.md
Name: pulse_width_counter

Overview:
Measures the width of a high pulse on `pulse_in` in clock cycles, then converts the cycle count to whole milliseconds with an internal sequential divider. It raises a one-cycle `done_tick` when the result is valid. A `read_time` strobe copies the current millisecond result into a history register. It sits between a sampled pulse/sensor input and a host or control block that polls the result.

Parameters:
- CLKS_PER_MS, 50_000, clock cycles per millisecond (50 MHz clock); divisor, must be ≥1
- COUNT_W, 20, width of cycle counter `count`
- TIME_W, 32, width of `time_ms` and `last_time_ms`

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- pulse_in  in  1  pulse under measurement; synchronous to clk
- read_time  in  1  level-sampled strobe; copies time_ms into last_time_ms
- ready  out  1  high while idle and armed for a new pulse
- done_tick  out  1  one-cycle strobe: measurement and conversion complete
- count  out  COUNT_W  measured width in clock cycles (held until next pulse starts)
- time_ms  out  TIME_W  floor(count / CLKS_PER_MS), zero-extended
- last_time_ms  out  TIME_W  value of time_ms captured at the last read_time

Behaviour:
- Reset (rst=0, async): state=IDLE; count, time_ms, last_time_ms, divider regs, pulse_prev all 0; done_tick=0; ready=1. Reset mid-measurement aborts it with no done_tick.
- pulse_prev: a register that samples pulse_in every cycle in every state; used for rising-edge detection.
- IDLE (ready=1): if pulse_in=1 and pulse_prev=0, then count<=1 and go to COUNT. Otherwise hold all outputs.
- COUNT (ready=0):
  - If pulse_in=1: count<=count+1, saturating at 2^COUNT_W-1 (no wrap).
  - If pulse_in=0: load the divider with dividend=count and divisor=CLKS_PER_MS, then go to DIVIDE.
  - Result: count equals the number of rising clk edges at which pulse_in sampled 1.
- DIVIDE (ready=0): restoring shift-subtract divider, one quotient bit per cycle, COUNT_W cycles. Then time_ms<=quotient (zero-extended) and go to DONE.
- DONE: done_tick=1 for exactly this cycle, ready=0; next state IDLE.
- Latency: done_tick is high COUNT_W+1 cycles after the first edge that samples pulse_in=0 in COUNT (21 cycles at default).
- Pulse activity during DIVIDE/DONE is ignored. A pulse already high when IDLE is re-entered is not counted, because no rising edge is seen. A new measurement needs pulse_in low for at least one sampled cycle in IDLE.
- read_time: on any edge where read_time=1, last_time_ms<=time_ms, regardless of state. During DONE, time_ms already holds the new result, so the new value is copied. Holding read_time high for N cycles repeats the copy (idempotent).
- count, time_ms: hold their values until the next measurement starts. count is overwritten at the start edge; time_ms only when the next DIVIDE completes.
- Outputs are registered except ready and done_tick, which are decoded from state.

Test Plan:
- Reset: rst=0 with pulse_in toggling → ready=1, done_tick=0, count=time_ms=last_time_ms=0. Release rst → still idle.
- Short pulse: pulse_in high for 5_000 cycles → count=5_000, time_ms=0, done_tick high exactly 1 cycle, 21 cycles after fall. read_time → last_time_ms=0.
- Multi-ms pulse: 150_000 cycles → count=150_000, time_ms=3. Then 125_000 cycles → count=125_000, time_ms=2. read_time after each → last_time_ms=3, then 2.
- Exact boundary: 49_999 cycles → time_ms=0; 50_000 → 1; 100_000 → 2.
- Saturation: pulse held 1_100_000 cycles → count=1_048_575, time_ms=20.
- Robustness:
  - pulse_in rises during DIVIDE → ignored, no second measurement until low then high in IDLE.
  - rst asserted mid-COUNT → no done_tick, all outputs 0.
